// File: rtl/cla_add_sequencer_if.sv
// Handshake, operand/result bus and shared 8-bit CLA slice hookup for cla_add_sequencer.
interface cla_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic [7:0]  slice_p;
    logic [7:0]  slice_g;
    logic        slice_cin;
    logic [7:0]  slice_s;
    logic        slice_po;
    logic        slice_go;

    modport slave (
        input  in_valid, op_sub, a, b, out_ready, slice_s, slice_po, slice_go,
        output in_ready, out_valid, result, cout, ovf,
               slice_a, slice_b, slice_p, slice_g, slice_cin
    );

    modport master (
        output in_valid, op_sub, a, b, out_ready, slice_s, slice_po, slice_go,
        input  in_ready, out_valid, result, cout, ovf,
               slice_a, slice_b, slice_p, slice_g, slice_cin
    );
endinterface

// File: rtl/cla_add_sequencer.sv
// 32-bit add/subtract sequenced as four byte passes through a shared external 8-bit CLA slice.
module cla_add_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    cla_add_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [1:0]         idx;
    logic               carry;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W-1:0]  sum;
    logic               cout_r;
    logic               ovf_r;
    logic               carry_next;
    logic [4:0]         bit_base;
    logic [7:0]         byte_a;
    logic [7:0]         byte_b;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic ovf_fn(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    assign bit_base   = {idx, 3'b000};
    assign byte_a     = opa[bit_base +: 8];
    assign byte_b     = opb[bit_base +: 8];
    assign carry_next = bus.slice_go | (bus.slice_po & carry);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = sum;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

    // The slice sees zeros whenever no byte pass is in progress.
    assign bus.slice_a   = (state == RUN) ? byte_a : 8'h00;
    assign bus.slice_b   = (state == RUN) ? byte_b : 8'h00;
    assign bus.slice_p   = (state == RUN) ? (byte_a | byte_b) : 8'h00;
    assign bus.slice_g   = (state == RUN) ? (byte_a & byte_b) : 8'h00;
    assign bus.slice_cin = (state == RUN) ? carry : 1'b0;

    // Operand capture; subtraction is folded in as A + ~B + 1.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.in_valid) begin
            opa <= bus.a;
            opb <= bus.op_sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            carry  <= 1'b0;
            sum    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        carry <= bus.op_sub;
                        idx   <= 2'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[bit_base +: 8] <= bus.slice_s;
                    carry              <= carry_next;
                    idx                <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state  <= DONE;
                        cout_r <= carry_next;
                        ovf_r  <= ovf_fn(opa[DATA_W-1], opb[DATA_W-1], bus.slice_s[7]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Randomized and directed bench for cla_add_sequencer with a behavioural 8-bit CLA slice.
module tb_cla_add_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    cla_add_sequencer_if bus ();

    cla_add_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared slice: lookahead carries from p/g, sum from the operand bytes.
    logic [8:0] sc;
    logic       gacc;
    always_comb begin
        sc    = '0;
        gacc  = 1'b0;
        sc[0] = bus.slice_cin;
        for (int i = 0; i < 8; i++) begin
            sc[i+1] = bus.slice_g[i] | (bus.slice_p[i] & sc[i]);
            gacc    = bus.slice_g[i] | (bus.slice_p[i] & gacc);
        end
        bus.slice_s  = bus.slice_a ^ bus.slice_b ^ sc[7:0];
        bus.slice_go = gacc;
        bus.slice_po = &bus.slice_p;
    end

    // Reference: {cout, ovf, result} from plain 32-bit and signed arithmetic.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic signed [33:0] sv;
        logic [31:0]        r;
        logic               c;
        logic               o;
        if (sub) begin
            sv = $signed({{2{x[31]}}, x}) - $signed({{2{y[31]}}, y});
            r  = x - y;
            c  = (x >= y);
        end else begin
            sv = $signed({{2{x[31]}}, x}) + $signed({{2{y[31]}}, y});
            r  = x + y;
            c  = (({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF);
        end
        o = (sv > 34'sh0_7FFF_FFFF) || (sv < -34'sh0_8000_0000);
        return {c, o, r};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction from IDLE; returns observed outputs and accept-to-valid latency.
    task automatic run_op(input logic [31:0] a_in, input logic [31:0] b_in, input logic sub,
                          input bit noise, input bit rand_ready,
                          output logic [31:0] r, output logic c, output logic o,
                          output int lat, output bit pg_ok);
        bit rdy;
        int n;
        bus.a         = a_in;
        bus.b         = b_in;
        bus.op_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat   = 0;
        pg_ok = 1'b1;
        while (!bus.out_valid && lat < 20) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = $urandom;
                bus.b        = $urandom;
                bus.op_sub   = 1'($urandom_range(0, 1));
            end
            if (bus.slice_p !== (bus.slice_a | bus.slice_b) || bus.slice_g !== (bus.slice_a & bus.slice_b))
                pg_ok = 1'b0;
            tick();
            lat++;
        end
        r = bus.result;
        c = bus.cout;
        o = bus.ovf;
        n = 0;
        do begin
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.out_ready = rdy;
            tick();
            n++;
        end while (!rdy && n < 50);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h0000_0001;
        bus.op_sub   = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.result !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h cout=%b ovf=%b, required 0/0/0", bus.result, bus.cout, bus.ovf);
        end
        checks++;
        if ({bus.slice_a, bus.slice_b, bus.slice_p, bus.slice_g, bus.slice_cin} !== 33'h0) begin
            failures++;
            $display("FAIL reset_slice_idle: a=%h b=%h p=%h g=%h cin=%b, required all 0",
                     bus.slice_a, bus.slice_b, bus.slice_p, bus.slice_g, bus.slice_cin);
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h0000_00FF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] vb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1111_1111};
        logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] vr [6] = '{32'h0000_0100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h2345_6789};
        logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] r;
        logic        c;
        logic        o;
        int          lat;
        bit          pg;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], 1'b0, 1'b0, r, c, o, lat, pg);
            checks++;
            if (r !== vr[i] || c !== vc[i] || o !== vo[i]) begin
                failures++;
                $display("FAIL directed_%0d: got result=%h cout=%b ovf=%b, required %h/%b/%b",
                         i, r, c, o, vr[i], vc[i], vo[i]);
            end
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL directed_latency_%0d: got %0d edges, required 4", i, lat);
            end
            checks++;
            if (bus.in_ready !== 1'b1 || !pg) begin
                failures++;
                $display("FAIL directed_return_%0d: in_ready=%b pg_ok=%b, required 1/1", i, bus.in_ready, pg);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] exp;
        logic [31:0] r0;
        logic        c0;
        logic        o0;
        int          n;
        bit          bad;
        exp = ref_op(32'hDEAD_BEEF, 32'h4321_0FED, 1'b1);
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h4321_0FED;
        bus.op_sub    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        r0 = bus.result;
        c0 = bus.cout;
        o0 = bus.ovf;
        checks++;
        if ({c0, o0, r0} !== exp) begin
            failures++;
            $display("FAIL bp_value: got %h, required %h", {c0, o0, r0}, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.op_sub   = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.result !== r0 || bus.cout !== c0 || bus.ovf !== o0 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                failures++;
                bad = 1'b1;
                $display("FAIL bp_hold_%0d: result=%h cout=%b ovf=%b in_ready=%b out_valid=%b, required %h/%b/%b/0/1",
                         i, bus.result, bus.cout, bus.ovf, bus.in_ready, bus.out_valid, r0, c0, o0);
            end
        end
        checks++;
        if ({bus.slice_a, bus.slice_b, bus.slice_p, bus.slice_g, bus.slice_cin} !== 33'h0) begin
            failures++;
            $display("FAIL bp_slice_done: a=%h b=%h cin=%b, required 0", bus.slice_a, bus.slice_b, bus.slice_cin);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_accept_on_release: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic        c;
        logic        o;
        int          lat;
        bit          pg;
        bit          seen;
        bus.a        = 32'hAAAA_5555;
        bus.b        = 32'h0F0F_F0F0;
        bus.op_sub   = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
            failures++;
            $display("FAIL midop_reset: in_ready=%b out_valid=%b result=%h, required 1/0/0",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midop_no_valid: out_valid pulsed=%b, required 0", seen);
        end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, r, c, o, lat, pg);
        checks++;
        if (r !== 32'h2345_6789 || c !== 1'b0 || o !== 1'b0 || lat !== 4) begin
            failures++;
            $display("FAIL midop_next: result=%h cout=%b ovf=%b lat=%0d, required 23456789/0/0/4", r, c, o, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [33:0] exp;
        logic [31:0] r;
        logic        c;
        logic        o;
        int          lat;
        bit          pg;
        int          t0;
        int          t1;
        for (int i = 0; i < 3; i++) begin
            x = $urandom;
            y = $urandom;
            s = 1'(i % 2);
            exp = ref_op(x, y, s);
            t0 = int'($time);
            run_op(x, y, s, 1'b0, 1'b0, r, c, o, lat, pg);
            t1 = int'($time);
            checks++;
            if ({c, o, r} !== exp || (t1 - t0) != 60) begin
                failures++;
                $display("FAIL b2b_%0d: got %h spacing=%0d, required %h spacing=60", i, {c, o, r}, t1 - t0, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [33:0] exp;
        logic [31:0] r;
        logic        c;
        logic        o;
        int          lat;
        bit          pg;
        int          shown;
        shown = 0;
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 7))
                0:       x = 32'hFFFF_FFFF;
                1:       x = 32'h8000_0000;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       y = 32'hFFFF_FFFF;
                1:       y = 32'h7FFF_FFFF;
                default: y = $urandom;
            endcase
            s   = 1'($urandom_range(0, 1));
            exp = ref_op(x, y, s);
            run_op(x, y, s, 1'b1, 1'b1, r, c, o, lat, pg);
            checks++;
            if ({c, o, r} !== exp || lat !== 4 || !pg) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_%0d: a=%h b=%h sub=%b got %h lat=%0d pg=%b, required %h lat=4 pg=1",
                             i, x, y, s, {c, o, r}, lat, pg, exp);
                end
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_sub    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
